// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with modulo limit, prescaler, synchronous clear,
// parallel load, terminal-count flag and registered wrap pulse.
// Optional build macro UPDOWN_CTR_SATURATE_EN: the counter saturates at 0 and
// MOD_MAX instead of wrapping, and wrap is never asserted.
module updown_counter_param #(
   parameter int unsigned WIDTH     = 4,
   parameter int unsigned MOD_MAX   = (2 ** WIDTH) - 1,
   parameter int unsigned RESET_VAL = 0,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sync_clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD_MAX);
   localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] count_d, count_q;
   logic             wrap_d, wrap_q;
   logic             step;

   // Prescaler: only present when more than one enabled cycle makes a step.
   if (PRESCALE > 1) begin : g_pre
      localparam int unsigned PW = $clog2(PRESCALE);
      localparam logic [PW-1:0] PreLast = PW'(PRESCALE - 1);

      logic [PW-1:0] pre_cnt_d, pre_cnt_q;

      assign step = en && (pre_cnt_q == PreLast);

      // Next phase: clear and load restart the phase; en=0 freezes it.
      always_comb begin
         pre_cnt_d = pre_cnt_q;
         if (sync_clr || load) begin
            pre_cnt_d = '0;
         end else if (en) begin
            pre_cnt_d = step ? '0 : pre_cnt_q + 1'b1;
         end
      end

      // Phase register.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            pre_cnt_q <= '0;
         end else begin
            pre_cnt_q <= pre_cnt_d;
         end
      end
   end else begin : g_no_pre
      assign step = en;
   end

   // Next count and wrap: clear beats load beats step; arithmetic is modulo MOD_MAX+1.
   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (sync_clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = (load_val > MaxVal) ? MaxVal : load_val;
      end else if (step) begin
         if (up_dn) begin
            if (count_q == MaxVal) begin
`ifdef UPDOWN_CTR_SATURATE_EN
               count_d = count_q;
`else
               count_d = '0;
               wrap_d  = 1'b1;
`endif
            end else begin
               count_d = count_q + 1'b1;
            end
         end else begin
            if (count_q == '0) begin
`ifdef UPDOWN_CTR_SATURATE_EN
               count_d = count_q;
`else
               count_d = MaxVal;
               wrap_d  = 1'b1;
`endif
            end else begin
               count_d = count_q - 1'b1;
            end
         end
      end
   end

   // Count and wrap registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= RstVal;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end

   // Terminal count follows up_dn combinationally.
   always_comb begin
      tc = up_dn ? (count_q == MaxVal) : (count_q == '0);
   end

   assign count = count_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed self-checking bench for updown_counter_param. Three instances share
// stimulus: a default 4-bit counter, a MOD_MAX=9 counter (RESET_VAL=5) and a
// MOD_MAX=9 counter with PRESCALE=3. Expectations adapt to UPDOWN_CTR_SATURATE_EN.
module tb_updown_counter_param;

`ifdef UPDOWN_CTR_SATURATE_EN
   localparam bit Sat = 1'b1;
`else
   localparam bit Sat = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       up_dn;
   logic       sync_clr;
   logic       load;
   logic [3:0] load_val;

   logic [3:0] count_a, count_b, count_c;
   logic       tc_a, tc_b, tc_c;
   logic       wrap_a, wrap_b, wrap_c;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   updown_counter_param #(.WIDTH(4)) dut_a (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sync_clr(sync_clr),
      .load(load), .load_val(load_val), .count(count_a), .tc(tc_a), .wrap(wrap_a)
   );

   updown_counter_param #(.WIDTH(4), .MOD_MAX(9), .RESET_VAL(5), .PRESCALE(1)) dut_b (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sync_clr(sync_clr),
      .load(load), .load_val(load_val), .count(count_b), .tc(tc_b), .wrap(wrap_b)
   );

   updown_counter_param #(.WIDTH(4), .MOD_MAX(9), .RESET_VAL(0), .PRESCALE(3)) dut_c (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .sync_clr(sync_clr),
      .load(load), .load_val(load_val), .count(count_c), .tc(tc_c), .wrap(wrap_c)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [3:0] v);
      en       = 1'b0;
      load     = 1'b1;
      load_val = v;
      tick();
      load     = 1'b0;
   endtask

   task automatic test_reset();
      int exp_cnt;
      reset = 1'b1; en = 1'b0; up_dn = 1'b1; sync_clr = 1'b0; load = 1'b0; load_val = '0;
      repeat (2) tick();
      n_checks++;
      if (count_a !== 4'd0) $display("FAIL reset_a count=%0d expected=0", count_a);
      else n_pass++;
      n_checks++;
      if (count_b !== 4'd5) $display("FAIL reset_b_val count=%0d expected=5", count_b);
      else n_pass++;
      n_checks++;
      if (wrap_a !== 1'b0) $display("FAIL reset_wrap wrap=%b expected=0", wrap_a);
      else n_pass++;
      reset = 1'b0;
      en    = 1'b1;
      repeat (3) tick();
      n_checks++;
      if (count_a !== 4'd3) $display("FAIL pre_async count=%0d expected=3", count_a);
      else n_pass++;
      // Assert reset between edges: must clear without a clock edge.
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (count_a !== 4'd0) $display("FAIL async_reset count=%0d expected=0", count_a);
      else n_pass++;
      #1 reset = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         exp_cnt = Sat ? ((i > 15) ? 15 : i) : (i % 16);
         n_checks++;
         if (count_a !== 4'(exp_cnt))
            $display("FAIL up_run step=%0d count=%0d expected=%0d", i, count_a, exp_cnt);
         else n_pass++;
         n_checks++;
         if (wrap_a !== (!Sat && i == 16))
            $display("FAIL up_wrap step=%0d wrap=%b expected=%b", i, wrap_a, (!Sat && i == 16));
         else n_pass++;
         n_checks++;
         if (tc_a !== (exp_cnt == 15))
            $display("FAIL up_tc step=%0d tc=%b expected=%b", i, tc_a, (exp_cnt == 15));
         else n_pass++;
      end
      en = 1'b0;
   endtask

   task automatic test_down();
      int cur;
      up_dn = 1'b0;
      do_load(4'd3);
      cur = 3;
      n_checks++;
      if (count_b !== 4'd3) $display("FAIL down_load count=%0d expected=3", count_b);
      else n_pass++;
      en = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         cur = (cur == 0) ? (Sat ? 0 : 9) : cur - 1;
         n_checks++;
         if (count_b !== 4'(cur))
            $display("FAIL down_run k=%0d count=%0d expected=%0d", k, count_b, cur);
         else n_pass++;
         n_checks++;
         if (wrap_b !== (!Sat && k == 3))
            $display("FAIL down_wrap k=%0d wrap=%b expected=%b", k, wrap_b, (!Sat && k == 3));
         else n_pass++;
         n_checks++;
         if (tc_b !== (cur == 0))
            $display("FAIL down_tc k=%0d tc=%b expected=%b", k, tc_b, (cur == 0));
         else n_pass++;
      end
      en = 1'b0;
   endtask

   task automatic test_prescale();
      up_dn = 1'b1;
      do_load(4'd0);
      en = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         n_checks++;
         if (count_c !== 4'(k / 3))
            $display("FAIL pre_run k=%0d count=%0d expected=%0d", k, count_c, k / 3);
         else n_pass++;
      end
      tick();
      en = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (count_c !== 4'd3) $display("FAIL pre_hold count=%0d expected=3", count_c);
      else n_pass++;
      en = 1'b1;
      tick();
      n_checks++;
      if (count_c !== 4'd3) $display("FAIL pre_phase count=%0d expected=3", count_c);
      else n_pass++;
      tick();
      n_checks++;
      if (count_c !== 4'd4) $display("FAIL pre_delayed count=%0d expected=4", count_c);
      else n_pass++;
      en = 1'b0;
   endtask

   task automatic test_priority();
      en = 1'b1; up_dn = 1'b1; sync_clr = 1'b1; load = 1'b1; load_val = 4'd7;
      tick();
      sync_clr = 1'b0;
      n_checks++;
      if (count_b !== 4'd0) $display("FAIL clr_over_load count=%0d expected=0", count_b);
      else n_pass++;
      n_checks++;
      if (count_c !== 4'd0) $display("FAIL clr_c count=%0d expected=0", count_c);
      else n_pass++;
      do_load(4'd14);
      n_checks++;
      if (count_b !== 4'd9) $display("FAIL load_clamp count=%0d expected=9", count_b);
      else n_pass++;
      n_checks++;
      if (count_a !== 4'd14) $display("FAIL load_noclamp count=%0d expected=14", count_a);
      else n_pass++;
      // Load must restart the prescaler phase: third enabled cycle steps.
      en = 1'b1; up_dn = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (count_c !== 4'd9) $display("FAIL load_phase_hold count=%0d expected=9", count_c);
      else n_pass++;
      tick();
      n_checks++;
      if (count_c !== 4'd8) $display("FAIL load_phase_step count=%0d expected=8", count_c);
      else n_pass++;
      en = 1'b0;
   endtask

   task automatic test_flip();
      logic [3:0] exp_seq [4];
      exp_seq = '{4'd6, 4'd5, 4'd6, 4'd5};
      do_load(4'd5);
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         up_dn = (k % 2 == 0);
         tick();
         n_checks++;
         if (count_b !== exp_seq[k])
            $display("FAIL flip k=%0d count=%0d expected=%0d", k, count_b, exp_seq[k]);
         else n_pass++;
      end
      do_load(4'd0);
      up_dn = 1'b0; #1;
      n_checks++;
      if (tc_b !== 1'b1) $display("FAIL tc_zero_down tc=%b expected=1", tc_b);
      else n_pass++;
      up_dn = 1'b1; #1;
      n_checks++;
      if (tc_b !== 1'b0) $display("FAIL tc_zero_up tc=%b expected=0", tc_b);
      else n_pass++;
      do_load(4'd9);
      #1;
      n_checks++;
      if (tc_b !== 1'b1) $display("FAIL tc_max_up tc=%b expected=1", tc_b);
      else n_pass++;
      up_dn = 1'b0; #1;
      n_checks++;
      if (tc_b !== 1'b0) $display("FAIL tc_max_down tc=%b expected=0", tc_b);
      else n_pass++;
   endtask

   task automatic test_limit();
      int cur;
      up_dn = 1'b1;
      do_load(4'd8);
      cur = 8;
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         cur = (cur == 9) ? (Sat ? 9 : 0) : cur + 1;
         n_checks++;
         if (count_b !== 4'(cur))
            $display("FAIL lim_up k=%0d count=%0d expected=%0d", k, count_b, cur);
         else n_pass++;
         n_checks++;
         if (wrap_b !== (!Sat && k == 1))
            $display("FAIL lim_up_wrap k=%0d wrap=%b expected=%b", k, wrap_b, (!Sat && k == 1));
         else n_pass++;
         n_checks++;
         if (tc_b !== (cur == 9))
            $display("FAIL lim_up_tc k=%0d tc=%b expected=%b", k, tc_b, (cur == 9));
         else n_pass++;
      end
      up_dn = 1'b0;
      do_load(4'd1);
      cur = 1;
      en = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         cur = (cur == 0) ? (Sat ? 0 : 9) : cur - 1;
         n_checks++;
         if (count_b !== 4'(cur))
            $display("FAIL lim_dn k=%0d count=%0d expected=%0d", k, count_b, cur);
         else n_pass++;
         n_checks++;
         if (tc_b !== (cur == 0))
            $display("FAIL lim_dn_tc k=%0d tc=%b expected=%b", k, tc_b, (cur == 0));
         else n_pass++;
      end
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_down();
      test_prescale();
      test_priority();
      test_flip();
      test_limit();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
